// File: rtl/modcnt_pkg.sv
// Shared types and defaults for the modulo counter FSM and its next-value logic.
// Optional saturating boundary behaviour is selected with MODCNT_SATURATE_EN.
package modcnt_pkg;

  localparam int unsigned NBITS_DEF = 16;
  localparam int unsigned SBITS_DEF = 4;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/modcnt_next.sv
// Combinational next-value and boundary detection for a modulo up/down counter.
// With MODCNT_SATURATE_EN defined the boundaries pin instead of wrapping.
module modcnt_next
  import modcnt_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned SBITS = SBITS_DEF
) (
  input  logic [NBITS-1:0] q,
  input  logic [SBITS-1:0] step,
  input  logic             dir,
  input  logic [NBITS-1:0] cnt_ini,
  input  logic [NBITS-1:0] cnt_rst,
  output logic [NBITS-1:0] nxt,
  output logic             wrap
);

  localparam int unsigned WW = NBITS + 1;

  logic [WW-1:0]    sum_w;
  logic [WW-1:0]    lo_w;
  logic [NBITS-1:0] top;

  // One extra bit keeps q+step and cnt_ini+step free of overflow
  always_comb begin
    sum_w = WW'(q) + WW'(step);
    lo_w  = WW'(cnt_ini) + WW'(step);
    top   = cnt_rst - NBITS'(1);
    nxt   = q;
    wrap  = 1'b0;
    if (step != '0) begin
`ifdef MODCNT_SATURATE_EN
      if (dir == DIR_UP) begin
        if (sum_w >= WW'(top)) begin
          nxt  = top;
          wrap = (q != top);
        end else begin
          nxt = sum_w[NBITS-1:0];
        end
      end else begin
        if (WW'(q) <= lo_w) begin
          nxt  = cnt_ini;
          wrap = (q != cnt_ini);
        end else begin
          nxt = q - NBITS'(step);
        end
      end
`else
      if (dir == DIR_UP) begin
        if (sum_w >= WW'(cnt_rst)) begin
          nxt  = cnt_ini;
          wrap = 1'b1;
        end else begin
          nxt = sum_w[NBITS-1:0];
        end
      end else begin
        if (WW'(q) < lo_w) begin
          nxt  = top;
          wrap = 1'b1;
        end else begin
          nxt = q - NBITS'(step);
        end
      end
`endif
    end
  end

endmodule

// File: rtl/modcnt_fsm.sv
// Registered modulo counter with start/stop/load control and one-shot mode.
// MODCNT_SATURATE_EN (in modcnt_next) switches wrapping to pinning at the bounds.
module modcnt_fsm
  import modcnt_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned SBITS = SBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             dir,
  input  logic             oneshot,
  input  logic [SBITS-1:0] step,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic [NBITS-1:0] cnt_ini,
  input  logic [NBITS-1:0] cnt_rst,
  output logic [NBITS-1:0] q,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [NBITS-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] nxt;
  logic             wrap;

  modcnt_next #(
    .NBITS (NBITS),
    .SBITS (SBITS)
  ) u_next (
    .q       (q_q),
    .step    (step),
    .dir     (dir),
    .cnt_ini (cnt_ini),
    .cnt_rst (cnt_rst),
    .nxt     (nxt),
    .wrap    (wrap)
  );

  assign cfg_err = (cnt_ini >= cnt_rst);
  assign q       = q_q;
  assign tick    = tick_q;
  assign busy    = busy_q;

  // Control priority: stop > load > start > count
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (load) begin
      q_d = load_val;
    end else if (start) begin
      q_d     = cnt_ini;
      state_d = RUN;
    end else if ((state_q == RUN) && enable && !cfg_err) begin
      q_d    = nxt;
      tick_d = wrap;
      if (wrap && oneshot) begin
        state_d = DONE;
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_modcnt_fsm.sv
// Self-checking bench for modcnt_fsm: directed scenarios plus randomized control,
// checked against an arithmetic reference model of the counter.
module tb_modcnt_fsm;

  localparam int unsigned NB = 16;
  localparam int unsigned SB = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, enable, dir, oneshot, load;
  logic [SB-1:0] step;
  logic [NB-1:0] load_val, cnt_ini, cnt_rst;
  logic [NB-1:0] q;
  logic          tick, busy, cfg_err;

  int n_assert = 0;
  int n_fail   = 0;

  int m_q;
  int m_state;
  bit m_tick;

  always #5 clk = ~clk;

  modcnt_fsm #(.NBITS(NB), .SBITS(SB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .enable   (enable),
    .dir      (dir),
    .oneshot  (oneshot),
    .step     (step),
    .load     (load),
    .load_val (load_val),
    .cnt_ini  (cnt_ini),
    .cnt_rst  (cnt_rst),
    .q        (q),
    .tick     (tick),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: one clock of the counter, in plain integer arithmetic
  task automatic model_step();
    int ini, rst, st, nq;
    bit hit;
    ini = int'(cnt_ini);
    rst = int'(cnt_rst);
    st  = int'(step);
    m_tick = 1'b0;
    if (stop) begin
      m_state = M_IDLE;
    end else if (load) begin
      m_q = int'(load_val);
    end else if (start) begin
      m_q = ini;
      m_state = M_RUN;
    end else if (m_state == M_RUN && enable && ini < rst && st > 0) begin
`ifdef MODCNT_SATURATE_EN
      if (!dir) begin
        hit = (m_q + st >= rst - 1);
        nq  = hit ? rst - 1 : m_q + st;
      end else begin
        hit = (m_q - st <= ini);
        nq  = hit ? ini : m_q - st;
      end
      m_tick = hit && (nq != m_q);
`else
      if (!dir) begin
        hit = (m_q + st >= rst);
        nq  = hit ? ini : m_q + st;
      end else begin
        hit = (m_q - st < ini);
        nq  = hit ? rst - 1 : m_q - st;
      end
      m_tick = hit;
`endif
      m_q = nq;
      if (m_tick && oneshot) m_state = M_DONE;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},       32'(q),       32'(m_q));
    chk({tag, ".tick"},    32'(tick),    32'(m_tick));
    chk({tag, ".busy"},    32'(busy),    32'(m_state == M_RUN));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(int'(cnt_ini) >= int'(cnt_rst)));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_ctl();
    start = 1'b0; stop = 1'b0; load = 1'b0; enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ctl();
    dir = 1'b0; oneshot = 1'b0; step = SB'(1);
    load_val = '0; cnt_ini = NB'(3); cnt_rst = NB'(7);
    m_q = 0; m_state = M_IDLE; m_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Basic up count, ini=3 rst=7 step=1
    start = 1'b1;
    cyc("up_start");
    chk("up_start_q", 32'(q), 32'd3);
    start = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc("up_run");
      if (i == 2) chk("up_at6", 32'(q), 32'd6);
      if (i == 3) begin
        chk("up_wrap_q", 32'(q), 32'd3);
        chk("up_wrap_tick", 32'(tick), 32'd1);
      end
    end

    // Down with step 3 from a loaded value
    idle_ctl();
    cnt_ini = NB'(0); cnt_rst = NB'(10); step = SB'(3); dir = 1'b1; load_val = NB'(8);
    start = 1'b1;
    cyc("dn_start");
    start = 1'b0; load = 1'b1;
    cyc("dn_load");
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc("dn_run");
      if (i == 2) begin
        chk("dn_wrap_q", 32'(q), 32'd9);
        chk("dn_wrap_tick", 32'(tick), 32'd1);
      end
    end

    // One-shot wrap then DONE
    idle_ctl();
    cnt_ini = NB'(0); cnt_rst = NB'(4); step = SB'(1); dir = 1'b0; oneshot = 1'b1;
    start = 1'b1;
    cyc("os_start");
    start = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc("os_run");
    chk("os_done_busy", 32'(busy), 32'd0);
    chk("os_done_tick", 32'(tick), 32'd1);
    for (int i = 0; i < 5; i++) cyc("os_hold");
    chk("os_hold_q", 32'(q), 32'd0);
    start = 1'b1;
    cyc("os_restart");
    chk("os_restart_busy", 32'(busy), 32'd1);
    oneshot = 1'b0;

    // Priority: stop beats load and counting at the wrap point
    idle_ctl();
    cnt_ini = NB'(3); cnt_rst = NB'(7); step = SB'(1); dir = 1'b0;
    start = 1'b1;
    cyc("pri_start");
    start = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) cyc("pri_run");
    load = 1'b1; load_val = NB'(2); stop = 1'b1;
    cyc("pri_collide");
    chk("pri_q", 32'(q), 32'd6);
    chk("pri_busy", 32'(busy), 32'd0);
    stop = 1'b0; enable = 1'b0;
    cyc("pri_load");
    chk("pri_load_q", 32'(q), 32'd2);
    load = 1'b0;

    // Config error holds q, then async reset mid-run
    cnt_ini = NB'(9); cnt_rst = NB'(9);
    start = 1'b1;
    cyc("cfg_start");
    start = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) cyc("cfg_hold");
    chk("cfg_err_flag", 32'(cfg_err), 32'd1);
    chk("cfg_q", 32'(q), 32'd9);
    cnt_rst = NB'(12);
    for (int i = 0; i < 4; i++) cyc("cfg_fixed");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    m_q = 0; m_state = M_IDLE; m_tick = 1'b0;
    #1 rst_n = 1'b1;
    idle_ctl();
    cyc("post_reset");

`ifdef MODCNT_SATURATE_EN
    cnt_ini = NB'(0); cnt_rst = NB'(5); step = SB'(2); dir = 1'b0;
    start = 1'b1;
    cyc("sat_start");
    start = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc("sat_up");
    chk("sat_up_q", 32'(q), 32'd4);
    dir = 1'b1;
    for (int i = 0; i < 3; i++) cyc("sat_dn");
    chk("sat_dn_q", 32'(q), 32'd0);
`endif

    // Randomized control and bounds
    idle_ctl();
    cnt_ini = NB'(2); cnt_rst = NB'(15);
    for (int i = 0; i < 600; i++) begin
      stop    = ($urandom_range(39) == 0);
      load    = ($urandom_range(24) == 0);
      start   = ($urandom_range(19) == 0);
      enable  = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) dir = ~dir;
      if ($urandom_range(49) == 0) oneshot = ~oneshot;
      if ($urandom_range(9) == 0) step = SB'($urandom_range(15));
      load_val = NB'($urandom_range(31));
      if ($urandom_range(59) == 0) begin
        cnt_ini = NB'($urandom_range(19));
        cnt_rst = NB'($urandom_range(23));
      end
      cyc("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/modcnt_fsm.md
Name: modcnt_fsm

Overview:
- Registered, parametrised modulo counter: the sequential successor of the combinational next-value counter logic.
- Adds up/down direction, a programmable step, parallel load, one-shot/continuous modes, start/stop control and a configuration-error flag.
- Sits in timer/prescaler paths; `tick` drives downstream event logic.

Parameters:
- NBITS, 16, counter/limit width.
- SBITS, 4, step width; the step is unsigned, 0 to 2^SBITS-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin counting from cnt_ini
- stop  in  1  return to IDLE, hold q
- enable  in  1  advance qualifier in RUN
- dir  in  1  0 = up, 1 = down
- oneshot  in  1  1 = stop after the first wrap
- step  in  SBITS  increment/decrement amount
- load  in  1  parallel load strobe
- load_val  in  NBITS  value for load
- cnt_ini  in  NBITS  lower bound (inclusive)
- cnt_rst  in  NBITS  upper bound (exclusive)
- q  out  NBITS  current count (registered)
- tick  out  1  one-cycle wrap pulse (registered)
- busy  out  1  high in RUN
- cfg_err  out  1  high while cnt_ini >= cnt_rst (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - q=0, tick=0, busy=0, state=IDLE.
  - Reset mid-count aborts immediately; there is no resume.
- States:
  - IDLE: q held.
  - RUN: counting.
  - DONE: one-shot expired, q held.
- Control priority per cycle: stop > load > start > count.
- stop: from any state go to IDLE and hold q. tick=0 that cycle.
- load:
  - q<=load_val; state is unchanged.
  - No range check. The next count step applies the normal boundary rules.
- start:
  - From IDLE or DONE: q<=cnt_ini, go to RUN.
  - In RUN it restarts: q<=cnt_ini.
- RUN with enable=1 and cfg_err=0:
  - Up: s=q+step computed in NBITS+1 bits. If s >= cnt_rst: q<=cnt_ini, tick=1. Else q<=s.
  - Down: if q < cnt_ini+step (NBITS+1 compare): q<=cnt_rst-1, tick=1. Else q<=q-step.
  - With step=1, up mode the counter wraps exactly when q+1 == cnt_rst, so q runs cnt_ini..cnt_rst-1.
  - step=0: q holds and no tick is generated.
- RUN with enable=0: q holds, tick=0.
- cfg_err=1 in RUN: q holds, tick=0, state stays RUN. Counting resumes once the bounds are fixed.
- oneshot=1 and a wrap occurs: q takes the wrap value, tick=1, next state is DONE. busy falls in the same cycle tick rises.
- Latency:
  - q and tick update on the clock edge following the qualifying inputs.
  - tick is high for exactly one cycle per wrap.
- Simultaneous load and wrap condition: load wins, no tick.
- Simultaneous start and stop: stop wins.

Optional Feature:
- Macro MODCNT_SATURATE_EN.
- Defined: on reaching a boundary the counter pins instead of wrapping.
  - Up pins at cnt_rst-1; down pins at cnt_ini.
  - tick pulses once on arrival and stays low while pinned.
  - Reversing dir leaves the pin.
  - oneshot still moves to DONE on arrival.
- Undefined: wrap behaviour as above. There is no saturation logic in the netlist.

Decomposition:
- Package modcnt_pkg:
  - state enum (IDLE, RUN, DONE);
  - DIR_UP=1'b0, DIR_DN=1'b1;
  - default NBITS/SBITS localparams.
- Sub-module modcnt_next: combinational next-value and boundary logic.
  - Inputs: q, step, dir, cnt_ini, cnt_rst.
  - Outputs: nxt, wrap.
  - Reusable by other timers.

Test Plan:
- Reset and basic up: NBITS=16, ini=3, rst=7, step=1, up, start, then enable 10 cycles. Expect q=3,4,5,6,3,4,5,6,3,4 and tick high on each 6->3 transition only.
- Down with step: ini=0, rst=10, step=3, dir=1, load_val=8, load, then enable. Expect q=8,5,2,9 with tick on 2->9, then 6.
- One-shot: ini=0, rst=4, oneshot=1. Expect q=0,1,2,3,0, single tick, then DONE with busy=0 and q held at 0 for 5 cycles; start re-enters RUN.
- Priority and collision: with q=6 (rst=7, up), assert load=1 (load_val=2), stop=1, enable=1 together. Expect IDLE, q=6, tick=0. Next cycle load only gives q=2 and state IDLE.
- Config error and async reset: ini=9, rst=9, start. Expect cfg_err=1 and q held at 9. Then drop rst_n mid-RUN between clock edges: expect q=0, busy=0, tick=0 immediately.
- MODCNT_SATURATE_EN: ini=0, rst=5, step=2, up. Expect q=0,2,4,4,4 with one tick on arrival at 4; setting dir=1 gives q=2,0,0 with one tick.
